rename_ckpt_ctrl: RTL
=====================

# rename_ckpt_ctrl

Checkpoint controller for the rename stage, adding nested-branch support. It owns NUM_CKPT rename-map/free-list/busy-table snapshot slots. Each branch or jump leaving decode gets a slot and a tag. When a branch resolves, the block releases its slot on a hit, or orders a restore from the slot and a squash of all younger tags on a miss.

## Interface
Parameters
- NUM_CKPT, default 4: number of checkpoint slots. Power of two, 2..8.
- TAG_W, default $clog2(NUM_CKPT): branch tag / slot index width.

Ports
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- alloc_req_i, input, 1: decode holds a valid, unstalled branch or jump this cycle.
- alloc_grant_o, output, 1: combinational; the slot is taken at this edge.
- alloc_tag_o, output, TAG_W: combinational; slot/tag given to the branch (the tail pointer).
- save_en_o, output, 1: combinational, equal to alloc_grant_o; the rename file snapshots into slot alloc_tag_o at this edge.
- br_valid_i, input, 1: branch resolution valid.
- br_tag_i, input, TAG_W: tag of the resolving branch.
- br_hit_i, input, 1: 1 means the prediction was correct.
- flush_i, input, 1: full pipeline flush; drops every checkpoint.
- restore_en_o, output, 1: registered; the rename file restores from restore_slot_o this cycle.
- restore_slot_o, output, TAG_W: registered; slot to restore.
- squash_mask_o, output, NUM_CKPT: registered; one-hot per tag; instructions carrying any set tag are killed.
- active_mask_o, output, NUM_CKPT: registered valid bit per slot.
- full_o, output, 1: registered; count == NUM_CKPT; decode stalls branches.
- busy_o, output, 1: registered; count != 0 or state == RECOVER.

## Operation
- State: head (oldest), tail (next alloc), count (TAG_W+1 bits), valid[NUM_CKPT], resolved[NUM_CKPT].
- FSM has two states.
  - RUN to RECOVER on an accepted miss.
  - RECOVER to RUN unconditionally after 1 cycle.
  - flush_i forces RUN.
- Grant rule: alloc_grant_o = alloc_req_i && !full_o && state==RUN && !miss_now && !flush_i.
  - miss_now = br_valid_i && valid[br_tag_i] && !resolved[br_tag_i] && !br_hit_i.
- On grant: valid[tail]=1, resolved[tail]=0, tail+1 (mod NUM_CKPT), count+1.
- Hit on a valid, unresolved tag: resolved[tag]=1. The slot is not freed until it reaches head.
- Retire: each cycle, if valid[head] && resolved[head], clear valid[head], head+1, count-1. At most one retire per cycle.
- Miss on tag t:
  - Clear valid for t and every slot younger than t, i.e. t through tail-1 circularly.
  - tail=t; count = count - number cleared.
  - Next cycle: restore_en_o=1, restore_slot_o=t, squash_mask_o = the cleared set.
- Resolution with an invalid or already resolved tag: ignored, no state change.
- Priority: rst_i > flush_i > miss > (hit, retire, grant). Hit, retire and grant combine in one cycle; count changes by +1, 0 or -1.
- A miss in the same cycle as a retire of head: if t == head, the retire is suppressed.
- flush_i: all valid/resolved cleared, head=tail=0, count=0.
  - Next cycle: squash_mask_o = all valid slots at the time of the flush, restore_en_o=0.

## Timing
- Reset values:
  - restore_en_o=0, restore_slot_o=0, squash_mask_o=0, active_mask_o=0.
  - full_o=0, busy_o=0.
  - head=tail=count=0, state RUN.
- alloc_grant_o, alloc_tag_o and save_en_o are combinational, valid the same cycle as alloc_req_i.
- Resolution-to-restore latency is 1 cycle. squash_mask_o and restore_en_o are high for exactly 1 cycle.
- No grant in the miss cycle or in the RECOVER cycle. The first grant is possible the cycle after RECOVER.
- full_o is registered. A retire in a cycle where full_o=1 does not enable a same-cycle grant; the grant is possible next cycle.
- Tail wrap: NUM_CKPT-1 wraps to 0. A miss on a slot younger than a wrapped head uses circular age, not numeric order.
- Reset asserted during RECOVER: next cycle all outputs are at reset values, with no pending restore.

## Test plan
- Reset, then 4 grants with NUM_CKPT=4 -> tags 0,1,2,3; full_o=1 after the 4th edge; 5th request gets alloc_grant_o=0.
- Tags 0..2 allocated; hit on tag 1 then tag 0 -> tag 0 retires next edge, tag 1 the following edge; count goes 3→2→1; active_mask_o=4'b0100.
- Tags 0..3 allocated; miss on tag 1 with alloc_req_i=1 -> no grant; next cycle restore_en_o=1, restore_slot_o=1, squash_mask_o=4'b1110; tail=1; count=1.
- Wrap: head=3, tags 3,0,1 valid; miss on tag 0 -> squash_mask_o=4'b0011, tail=0, only slot 3 remains active.
- Miss and flush_i in the same cycle with tags 0,1 valid -> flush wins; restore_en_o=0; squash_mask_o=4'b0011; count=0; a grant is allowed the next cycle.
- Resolution with an invalid tag, or a second hit on a resolved tag -> no change to any output or counter.

Source files
------------

// File: rtl/rename_ckpt_ctrl.sv
// Rename-stage checkpoint controller.
// Hands out NUM_CKPT snapshot slots to branches in age order (head = oldest,
// tail = next free). A correct prediction marks its slot resolved; slots only
// retire in order from head. A misprediction kills its own slot and everything
// younger, then issues a one-cycle restore/squash the following cycle.
module rename_ckpt_ctrl #(
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = $clog2(NUM_CKPT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_req_i,
    output logic                alloc_grant_o,
    output logic [TAG_W-1:0]    alloc_tag_o,
    output logic                save_en_o,
    input  logic                br_valid_i,
    input  logic [TAG_W-1:0]    br_tag_i,
    input  logic                br_hit_i,
    input  logic                flush_i,
    output logic                restore_en_o,
    output logic [TAG_W-1:0]    restore_slot_o,
    output logic [NUM_CKPT-1:0] squash_mask_o,
    output logic [NUM_CKPT-1:0] active_mask_o,
    output logic                full_o,
    output logic                busy_o
);

    typedef enum logic {ST_RUN, ST_RECOVER} state_e;

    localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(NUM_CKPT);

    state_e                state_q, state_d;
    logic [TAG_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]        count_q, count_d;
    logic [NUM_CKPT-1:0]   valid_q, valid_d, res_q, res_d;
    logic                  rest_en_q, rest_en_d;
    logic [TAG_W-1:0]      rest_slot_q, rest_slot_d;
    logic [NUM_CKPT-1:0]   squash_q, squash_d;
    logic                  full_q, busy_q;

    logic                  tgt_live, miss_now, hit_now, retire_ok, retire_m;
    logic [TAG_W-1:0]      t_rel;
    logic [NUM_CKPT-1:0]   clr_mask;

    // A resolution only matters for a live, still-unresolved slot.
    assign tgt_live  = br_valid_i & valid_q[br_tag_i] & ~res_q[br_tag_i];
    assign miss_now  = tgt_live & ~br_hit_i;
    assign hit_now   = tgt_live & br_hit_i;
    assign retire_ok = valid_q[head_q] & res_q[head_q];
    // The head retire still happens alongside a miss unless the miss is on head itself.
    assign retire_m  = retire_ok & (br_tag_i != head_q);

    // Age of the mispredicted slot relative to head; slot count is a power of
    // two so the subtraction wraps naturally and gives circular age.
    assign t_rel = br_tag_i - head_q;

    // Slots at or younger than the mispredicted one are the ones to kill.
    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_clr
        logic [TAG_W-1:0] rel;
        assign rel         = TAG_W'(g) - head_q;
        assign clr_mask[g] = valid_q[g] & (rel >= t_rel);
    end

    assign alloc_grant_o = alloc_req_i & ~full_q & (state_q == ST_RUN) & ~miss_now & ~flush_i;
    assign alloc_tag_o   = tail_q;
    assign save_en_o     = alloc_grant_o;

    assign restore_en_o   = rest_en_q;
    assign restore_slot_o = rest_slot_q;
    assign squash_mask_o  = squash_q;
    assign active_mask_o  = valid_q;
    assign full_o         = full_q;
    assign busy_o         = busy_q;

    // Next-state: flush beats miss, miss beats the normal hit/retire/grant mix.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        res_d       = res_q;
        rest_en_d   = 1'b0;
        rest_slot_d = rest_slot_q;
        squash_d    = '0;
        if (flush_i) begin
            state_d  = ST_RUN;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            valid_d  = '0;
            res_d    = '0;
            squash_d = valid_q;
        end else if (miss_now) begin
            state_d     = (state_q == ST_RUN) ? ST_RECOVER : ST_RUN;
            valid_d     = valid_q & ~clr_mask;
            res_d       = res_q & ~clr_mask;
            if (retire_m) begin
                valid_d[head_q] = 1'b0;
                res_d[head_q]   = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end
            tail_d      = br_tag_i;
            count_d     = {1'b0, t_rel} - (TAG_W+1)'(retire_m);
            rest_en_d   = 1'b1;
            rest_slot_d = br_tag_i;
            squash_d    = clr_mask;
        end else begin
            state_d = ST_RUN;
            if (hit_now) res_d[br_tag_i] = 1'b1;
            if (retire_ok) begin
                valid_d[head_q] = 1'b0;
                res_d[head_q]   = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end
            if (alloc_grant_o) begin
                valid_d[tail_q] = 1'b1;
                res_d[tail_q]   = 1'b0;
                tail_d          = tail_q + TAG_W'(1);
            end
            count_d = count_q + (TAG_W+1)'(alloc_grant_o) - (TAG_W+1)'(retire_ok);
        end
    end

    // State and registered outputs; full/busy are precomputed from next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            res_q       <= '0;
            rest_en_q   <= 1'b0;
            rest_slot_q <= '0;
            squash_q    <= '0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            res_q       <= res_d;
            rest_en_q   <= rest_en_d;
            rest_slot_q <= rest_slot_d;
            squash_q    <= squash_d;
            full_q      <= (count_d == CNT_FULL);
            busy_q      <= (count_d != '0) || (state_d == ST_RECOVER);
        end
    end

endmodule
